// File: rtl/mem_wb_stage_pkg.sv
// Shared types and default parameters for the MEM/WB stage.
package mem_wb_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned ADDR_BASE_DEF   = 1024;
  localparam int unsigned ADDR_W_DEF      = 18;
  localparam int unsigned TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/sram_req_fsm.sv
// SRAM request sequencer: IDLE/BUSY state plus the BUSY-cycle timeout counter.
module sram_req_fsm
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_c;

  assign last_c    = (cnt_q == CNT_LAST);
  assign busy_o    = (state_q == BUSY);
  // Ack wins over the timeout when both land in the final BUSY cycle.
  assign done_o    = busy_o & ack_i;
  assign timeout_o = busy_o & ~ack_i & last_c;

  // State and counter: count BUSY cycles from 0, leave on ack or on the last allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_i) state_q <= BUSY;
        end
        BUSY: begin
          if (ack_i || last_c) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one SRAM access per load/store and registers the write-back port.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic [3:0]        dest_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       st_val_in,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack,
  output logic              freeze,
  output logic              write_back_en,
  output logic [3:0]        dest_wb,
  output logic [31:0]       result_wb,
  output logic              mem_err
);

  logic              mem_op_c;
  logic              start_c;
  logic              busy;
  logic              done_c;
  logic              timeout_c;
  logic [ADDR_W-1:0] addr_c;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        dest_cap_q;
  logic              wb_en_cap_q;

  logic              wb_en_q;
  logic [3:0]        dest_wb_q;
  logic [31:0]       result_wb_q;
  logic              mem_err_q;

  assign mem_op_c = valid_in & (mem_r_en_in | mem_w_en_in);
  assign start_c  = ~busy & mem_op_c;
  // Byte address relative to the SRAM base, turned into a word index; wrap is allowed.
  assign addr_c   = ADDR_W'((alu_res_in - 32'(ADDR_BASE)) >> 2);

  sram_req_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_req_fsm (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (start_c),
    .ack_i    (sram_ack),
    .busy_o   (busy),
    .done_o   (done_c),
    .timeout_o(timeout_c)
  );

  // Stall from the issuing cycle until the cycle the access resolves.
  assign freeze = start_c | (busy & ~done_c & ~timeout_c);

  assign sram_req      = busy;
  assign sram_we       = we_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign write_back_en = wb_en_q;
  assign dest_wb       = dest_wb_q;
  assign result_wb     = result_wb_q;
  assign mem_err       = mem_err_q;

  // Capture the memory request on entry to BUSY; a simultaneous read+write is a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_cap_q  <= '0;
      wb_en_cap_q <= 1'b0;
    end else if (start_c) begin
      we_q        <= mem_w_en_in;
      addr_q      <= addr_c;
      wdata_q     <= st_val_in;
      dest_cap_q  <= dest_in;
      wb_en_cap_q <= wb_en_in;
    end
  end

  // One-cycle write-back register and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q     <= 1'b0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      if (busy) begin
        if (done_c && !we_q) begin
          wb_en_q     <= wb_en_cap_q;
          dest_wb_q   <= dest_cap_q;
          result_wb_q <= sram_rdata;
        end else if (timeout_c) begin
          mem_err_q <= 1'b1;
        end
      end else if (valid_in && !mem_op_c) begin
        wb_en_q     <= wb_en_in;
        dest_wb_q   <= dest_in;
        result_wb_q <= alu_res_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;

  localparam int unsigned TMO = 15;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in;
  logic [31:0] st_val_in;
  logic        sram_req;
  logic        sram_we;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;
  logic        freeze;
  logic        write_back_en;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        mem_err;

  int n_tests;
  int n_fail;
  bit err_m;

  mem_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .wb_en_in     (wb_en_in),
    .dest_in      (dest_in),
    .alu_res_in   (alu_res_in),
    .st_val_in    (st_val_in),
    .sram_req     (sram_req),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ack     (sram_ack),
    .freeze       (freeze),
    .write_back_en(write_back_en),
    .dest_wb      (dest_wb),
    .result_wb    (result_wb),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction through the stage; k = BUSY cycle carrying the ack (k > TMO: never acked).
  task automatic do_txn(input bit v, input bit rd, input bit wr, input bit wbe,
                        input logic [3:0] dest, input logic [31:0] alu,
                        input logic [31:0] st, input int k, input logic [31:0] rdata);
    bit          mem;
    bit          timed_out;
    bit          done;
    int          j;
    int          fz;
    logic [17:0] exp_addr;

    valid_in    = v;
    mem_r_en_in = rd;
    mem_w_en_in = wr;
    wb_en_in    = wbe;
    dest_in     = dest;
    alu_res_in  = alu;
    st_val_in   = st;
    sram_ack    = 1'($urandom_range(0, 1));
    sram_rdata  = $urandom;
    mem         = v && (rd || wr);

    @(negedge clk);
    check("wb_one_cycle", 32'(write_back_en), 32'd0);
    check("freeze_issue", 32'(freeze), 32'(mem));
    fz = freeze ? 1 : 0;
    @(posedge clk); #1;

    if (mem) begin
      exp_addr  = 18'((alu - 32'd1024) / 32'd4);
      timed_out = (k > int'(TMO));
      done      = 1'b0;
      j         = 0;
      while (!done) begin
        j++;
        sram_ack   = (j == k);
        sram_rdata = (j == k) ? rdata : $urandom;
        @(negedge clk);
        check("busy_req", 32'(sram_req), 32'd1);
        check("busy_we", 32'(sram_we), 32'(wr));
        check("busy_addr", 32'(sram_addr), 32'(exp_addr));
        if (wr) check("busy_wdata", sram_wdata, st);
        check("busy_freeze", 32'(freeze), 32'((j != k) && (j != int'(TMO))));
        if (freeze) fz++;
        @(posedge clk); #1;
        if (j == k || j == int'(TMO)) done = 1'b1;
      end
      sram_ack = 1'($urandom_range(0, 1));
      valid_in = 1'b0;
      if (timed_out) err_m = 1'b1;
      @(negedge clk);
      check("freeze_total", 32'(fz), timed_out ? 32'(TMO) : 32'(k));
      check("req_dropped", 32'(sram_req), 32'd0);
      check("mem_wb_en", 32'(write_back_en), 32'(!wr && !timed_out && wbe));
      if (!wr && !timed_out) begin
        check("mem_dest", 32'(dest_wb), 32'(dest));
        check("mem_result", result_wb, rdata);
      end
      check("mem_err", 32'(mem_err), 32'(err_m));
    end else begin
      valid_in = 1'b0;
      sram_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("alu_wb_en", 32'(write_back_en), 32'(v && wbe));
      if (v) begin
        check("alu_dest", 32'(dest_wb), 32'(dest));
        check("alu_result", result_wb, alu);
      end
      check("alu_mem_err", 32'(mem_err), 32'(err_m));
      check("alu_req", 32'(sram_req), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    err_m       = 1'b0;
    rst         = 1'b0;
    valid_in    = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b0;
    dest_in     = '0;
    alu_res_in  = '0;
    st_val_in   = '0;
    sram_rdata  = '0;
    sram_ack    = 1'b0;

    #1;
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_we", 32'(sram_we), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    check("rst_wb_en", 32'(write_back_en), 32'd0);
    check("rst_dest", 32'(dest_wb), 32'd0);
    check("rst_result", result_wb, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_txn(1, 0, 0, 1, 4'd3, 32'h55, 32'h0, 0, 32'h0);
    do_txn(1, 1, 0, 1, 4'd7, 32'd1032, 32'h0, 3, 32'hDEADBEEF);
    do_txn(1, 0, 1, 1, 4'd2, 32'd1024, 32'h1234, 1, 32'h0);
    do_txn(1, 1, 1, 1, 4'd5, 32'd1100, 32'hCAFE, 2, 32'h77);
    do_txn(0, 1, 0, 1, 4'd9, 32'd2000, 32'h0, 1, 32'h0);
    do_txn(1, 0, 0, 0, 4'd4, 32'h99, 32'h0, 0, 32'h0);
    do_txn(1, 1, 0, 1, 4'd6, 32'd1028, 32'h0, 15, 32'hA5A5A5A5);
    do_txn(1, 1, 0, 1, 4'd8, 32'd1040, 32'h0, 99, 32'h0);

    // Randomized instruction mix, including wrapped addresses and ack-free timeouts
    for (int n = 0; n < 150; n++) begin
      bit          v;
      bit          rd;
      bit          wr;
      logic [31:0] alu;
      v   = ($urandom_range(0, 7) != 0);
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      alu = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 4095));
      do_txn(v, rd, wr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), alu,
             $urandom, int'($urandom_range(1, 18)), $urandom);
    end

    // Reset during the second BUSY cycle of a load
    valid_in    = 1'b1;
    mem_r_en_in = 1'b1;
    mem_w_en_in = 1'b0;
    wb_en_in    = 1'b1;
    dest_in     = 4'd1;
    alu_res_in  = 32'd1040;
    sram_ack    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(sram_req), 32'd1);
    rst = 1'b0;
    #1;
    err_m = 1'b0;
    check("mid_rst_req", 32'(sram_req), 32'd0);
    check("mid_rst_wb_en", 32'(write_back_en), 32'd0);
    check("mid_rst_mem_err", 32'(mem_err), 32'(err_m));
    check("mid_rst_addr", 32'(sram_addr), 32'd0);
    check("mid_rst_freeze", 32'(freeze), 32'd1);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_wb_en", 32'(write_back_en), 32'd0);
      check("post_rst_req", 32'(sram_req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter ADDR_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-002 Parameter ADDR_W, default 18, SRAM word-address width.
REQ-003 Parameter TIMEOUT_CYC, default 15, max BUSY cycles awaiting sram_ack.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 valid_in  in  1  EX/MEM holds a valid instruction.
REQ-007 mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  load, store, register write-back request.
REQ-008 dest_in  in  4  destination register index.
REQ-009 alu_res_in  in  32  ALU result or byte address.
REQ-010 st_val_in  in  32  store data.
REQ-011 sram_req  out  1  SRAM access request, level.
REQ-012 sram_we  out  1  1 = write, 0 = read; valid while sram_req=1.
REQ-013 sram_addr  out  ADDR_W  word address.
REQ-014 sram_wdata  out  32  store data.
REQ-015 sram_rdata  in  32  read data, valid when sram_ack=1.
REQ-016 sram_ack  in  1  one-cycle completion pulse.
REQ-017 freeze  out  1  stall upstream stages.
REQ-018 write_back_en, dest_wb[3:0], result_wb[31:0]  out  write-back port into the register file.
REQ-019 mem_err  out  1  sticky timeout flag.

Function
REQ-020 FSM states: IDLE and BUSY; the write-back port is a registered one-cycle output stage.
REQ-021 IDLE with valid_in=1 and mem_r_en_in=mem_w_en_in=0: next edge drives write_back_en=wb_en_in, dest_wb=dest_in, result_wb=alu_res_in for one cycle; freeze=0.
REQ-022 IDLE with valid_in=0: next edge drives write_back_en=0.
REQ-023 IDLE with valid_in=1 and a memory op: freeze=1 combinationally in the same cycle; next edge enters BUSY and captures op type, dest_in, wb_en_in, st_val_in and address.
REQ-024 Address = ((alu_res_in - ADDR_BASE) >> 2), truncated to ADDR_W bits; low two bits ignored; wrap-around is not an error.
REQ-025 If mem_r_en_in and mem_w_en_in are both 1, perform the write.
REQ-026 In BUSY: sram_req=1, with sram_we/sram_addr/sram_wdata held constant until the exit edge; freeze=1 except in the cycle sram_ack=1.
REQ-027 BUSY with sram_ack=1: freeze=0; next edge returns to IDLE and drops sram_req.
REQ-028 On a read exit: write_back_en=captured wb_en, dest_wb=captured dest, result_wb=sram_rdata for one cycle.
REQ-029 On a write exit: write_back_en=0.
REQ-030 Inputs are ignored during BUSY; upstream holds them stable while freeze=1.
REQ-031 BUSY cycle counter starts at 0 on entry; when it reaches TIMEOUT_CYC-1 without ack: freeze=0 that cycle, next edge returns to IDLE, sets mem_err=1, write_back_en=0.
REQ-032 sram_ack in the timeout cycle takes priority: normal completion, no error.
REQ-033 sram_ack outside BUSY is ignored.
REQ-034 Latency: non-memory op 1 cycle; memory op = SRAM ack latency + 1.

Reset
REQ-035 rst=0 asynchronously forces IDLE, counter=0, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0, write_back_en=0, dest_wb=0, result_wb=0, mem_err=0.
REQ-036 Reset mid-BUSY abandons the access with no write-back; freeze then follows REQ-023 from IDLE.
REQ-037 mem_err clears only on reset.

Structure
REQ-038 The shared package holds the state enum (IDLE, BUSY) and the default ADDR_BASE, ADDR_W and TIMEOUT_CYC constants.
REQ-039 The request FSM plus timeout counter forms one sub-module, sram_req_fsm; datapath and the output register stay in mem_wb_stage.

Verification
REQ-040 ALU pass-through: valid, wb_en, dest=3, alu_res=0x55 -> next cycle write_back_en=1, dest_wb=3, result_wb=0x55, freeze never 1.
REQ-041 Load: alu_res=1032, ack after 3 cycles with rdata=0xDEADBEEF -> sram_addr=2, sram_we=0, freeze high 3 cycles, then write_back_en=1, result_wb=0xDEADBEEF for one cycle.
REQ-042 Store: alu_res=1024, st_val=0x1234, ack after 1 cycle -> sram_we=1, sram_addr=0, sram_wdata=0x1234, write_back_en stays 0.
REQ-043 Timeout: load, no ack -> sram_req high exactly 15 cycles, then mem_err=1, freeze=0, no write-back.
REQ-044 Ack on the 15th BUSY cycle -> normal completion, mem_err=0.
REQ-045 rst=0 asserted on the 2nd BUSY cycle -> sram_req=0 immediately, no write-back pulse after release.
